// File: rtl/matrix_pkg.sv
// matrix_pkg: frame geometry, pixel/word widths and controller state encoding shared by the matrix datapath.
package matrix_pkg;
    localparam int ROW_PIX = 28;
    localparam int ROWS    = 28;
    localparam int PIX_W   = 8;
    localparam int WORD_W  = 32;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DRAIN
    } state_t;
endpackage

// File: rtl/result_fifo.sv
// result_fifo: synchronous word FIFO; a push into a full FIFO is taken when the head pops in the same cycle.
module result_fifo
    import matrix_pkg::*;
#(
    parameter int W = WORD_W,
    parameter int D = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [W-1:0]         din,
    input  logic                 pop,
    output logic [W-1:0]         dout,
    output logic                 full,
    output logic                 empty,
    output logic [$clog2(D):0]   count
);
    localparam int AW = $clog2(D);
    logic [W-1:0] mem [D];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;
    assign count   = wr_ptr - rd_ptr;
    assign empty   = count == '0;
    assign full    = count == (AW+1)'(D);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head is read straight out of the storage flops, so it is valid the cycle after its push.
    assign dout    = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < D; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/result_buffer.sv
// result_buffer: requantises ALU results to 8 bits, packs 4 pixels per word and queues words for the store path.
// Defining RESULT_BUF_SAT_CNT_EN adds the per-frame clamp counter on port sat_count.
module result_buffer #(
    parameter int ACC_W   = 20,
    parameter int SHIFT   = 4,
    parameter int ROW_PIX = matrix_pkg::ROW_PIX,
    parameter int ROWS    = matrix_pkg::ROWS,
    parameter int FIFO_D  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          res_valid,
    input  logic signed [ACC_W-1:0]       res_data,
    output logic                          res_ready,
    output logic                          word_valid,
    output logic [matrix_pkg::WORD_W-1:0] word_data,
    input  logic                          word_ready,
    output logic                          row_done,
    output logic                          frame_done,
    output logic                          busy
`ifdef RESULT_BUF_SAT_CNT_EN
    ,
    output logic [15:0]                   sat_count
`endif
);
    import matrix_pkg::*;
    localparam int CW = $clog2(ROW_PIX);
    localparam int RW = $clog2(ROWS);
    state_t                    state;
    logic [CW-1:0]             col;
    logic [RW-1:0]             row;
    logic [3*PIX_W-1:0]        pack;
    logic signed [ACC_W-1:0]   v;
    logic                      neg;
    logic                      big;
    logic [PIX_W-1:0]          pix;
    logic                      accept;
    logic                      push;
    logic                      pop;
    logic                      last_col;
    logic                      last_pix;
    logic                      start_ok;
    logic                      drain_done;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(FIFO_D):0]   fifo_count;
    assign v   = res_data >>> SHIFT;
    assign neg = v[ACC_W-1];
    assign big = !neg && |v[ACC_W-2:PIX_W];
    assign pix = neg ? '0 : big ? '1 : v[PIX_W-1:0];
    // Hold the 4th pixel off only when its word would have nowhere to go.
    assign res_ready  = (state == ST_ACTIVE) && !(col[1:0] == 2'd3 && fifo_full);
    assign accept     = res_valid && res_ready;
    assign push       = accept && col[1:0] == 2'd3;
    assign word_valid = !fifo_empty;
    assign pop        = word_valid && word_ready;
    assign last_col   = col == CW'(ROW_PIX - 1);
    assign last_pix   = last_col && row == RW'(ROWS - 1);
    assign start_ok   = start && state == ST_IDLE && !frame_done;
    assign drain_done = fifo_empty || (pop && fifo_count == ($clog2(FIFO_D)+1)'(1));
    result_fifo #(.W(WORD_W), .D(FIFO_D)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({pix, pack}),
        .pop   (pop),
        .dout  (word_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            col        <= '0;
            row        <= '0;
            pack       <= '0;
            row_done   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            row_done   <= push && last_col;
            frame_done <= 1'b0;
            if (start_ok) begin
                state <= ST_ACTIVE;
                busy  <= 1'b1;
            end
            if (state == ST_DRAIN && drain_done) begin
                state      <= ST_IDLE;
                frame_done <= 1'b1;
                busy       <= 1'b0;
            end
            // Pixels shift in from the top so the first of each group lands in the lowest byte.
            if (accept) begin
                pack <= {pix, pack[3*PIX_W-1:PIX_W]};
                col  <= last_col ? '0 : col + CW'(1);
                if (last_col) row <= last_pix ? '0 : row + RW'(1);
                if (last_pix) state <= ST_DRAIN;
            end
        end
    end
`ifdef RESULT_BUF_SAT_CNT_EN
    logic sat;
    assign sat = neg || big;
    always_ff @(posedge clk) begin
        if (rst || start_ok) sat_count <= '0;
        else if (accept && sat && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_result_buffer.sv
// tb_result_buffer: directed self-checking bench for result_buffer framing, packing, clamping, backpressure and reset.
module tb_result_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        res_valid = 1'b0;
    logic [19:0] res_data = '0;
    logic        word_ready = 1'b0;
    logic        res_ready, word_valid, row_done, frame_done, busy;
    logic [31:0] word_data;
`ifdef RESULT_BUF_SAT_CNT_EN
    logic [15:0] sat_count;
`endif
    int          errors = 0, checks = 0;
    logic [31:0] q[$];
    logic [23:0] mpack = '0;
    int          mlane = 0, words_seen = 0, rd_cnt = 0, fd_cnt = 0, waits = 0;
    bit          rand_ready = 1'b0, stall_prev = 1'b0;
    logic [31:0] data_prev = '0;

    result_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .row_done   (row_done),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef RESULT_BUF_SAT_CNT_EN
        ,
        .sat_count  (sat_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input logic [19:0] d);
        int s;
        s = int'($signed(d)) >>> 4;
        return s < 0 ? 8'd0 : s > 255 ? 8'd255 : 8'(s);
    endfunction

    // Offer one result, wait (bounded) for acceptance, then record it in the word model.
    task automatic send(input logic [19:0] d);
        int n = 0;
        bit ok;
        logic [7:0] p;
        res_valid = 1'b1;
        res_data  = d;
        do begin @(negedge clk); n++; end while (res_ready !== 1'b1 && n < 1000);
        waits += n;
        ok = res_ready === 1'b1;
        if (!ok) begin
            res_valid = 1'b0;
            chk("send_timeout", 32'(res_ready), 32'd1);
        end
        @(posedge clk); #1;
        res_valid = 1'b0;
        if (ok) begin
            p = exp_pix(d);
            if (mlane == 3) begin
                q.push_back({p, mpack});
                mlane = 0;
            end else begin
                mpack[mlane*8 +: 8] = p;
                mlane++;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_frame_done(input int limit);
        int n = 0;
        do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < limit);
        chk("frame_done_seen", 32'(frame_done), 32'd1);
    endtask

    // Word scoreboard, hold-stability and pulse counting, sampled on the falling edge.
    always @(negedge clk) begin
        if (word_valid === 1'b1 && word_ready === 1'b1) begin
            words_seen++;
            if (q.size() == 0) chk("extra_word", 32'(q.size()), 32'd1);
            else chk("word", word_data, q.pop_front());
        end
        if (stall_prev && word_valid === 1'b1) chk("stable_hold", word_data, data_prev);
        stall_prev = word_valid === 1'b1 && word_ready !== 1'b1;
        data_prev  = word_data;
        if (row_done === 1'b1) rd_cnt++;
        if (frame_done === 1'b1) begin
            fd_cnt++;
            chk("busy_at_done", 32'(busy), 32'd0);
            chk("queue_empty_at_done", 32'(q.size()), 32'd0);
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_ready) word_ready = $urandom_range(0, 3) != 0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, rd_base, fd_base;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_ready", 32'(res_ready), 32'd0);
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_word_data", word_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_row_done", 32'(row_done), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        // Frame 1, row 0: 16*k requantises to k.
        word_ready = 1'b1;
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) send(20'(16 * k));
        chk("first_word_valid", 32'(word_valid), 32'd1);
        chk("first_word", word_data, 32'h03020100);
        for (int k = 4; k < 28; k++) send(20'(16 * k));
        chk("row0_done_pulse", 32'(row_done), 32'd1);
        @(posedge clk); #1;
        chk("row0_done_single", 32'(row_done), 32'd0);
        chk("row0_words", 32'(words_seen), 32'd7);
        // Row 1 lanes 0-3: clamping at both bounds.
        send(20'hFFFFB);
        send(20'h01000);
        send(20'h7FFFF);
        send(20'h00030);
        chk("clamp_word", word_data, 32'h03FFFF00);
`ifdef RESULT_BUF_SAT_CNT_EN
        chk("sat_count_3", 32'(sat_count), 32'd3);
`endif
        repeat (3) begin @(posedge clk); #1; end
        // Store path stalled: 4 words plus 3 pixels fit, then the 4th pixel is held off.
        word_ready = 1'b0;
        waits = 0;
        for (int k = 0; k < 19; k++) send(20'(16 * k + 160));
        chk("no_stall_19", 32'(waits), 32'd19);
        res_valid = 1'b1;
        res_data  = 20'h00AA0;
        @(negedge clk);
        chk("ready_low_full", 32'(res_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("ready_still_low", 32'(res_ready), 32'd0);
        chk("word_held", 32'(word_valid), 32'd1);
        chk("head_in_order", word_data, q[0]);
        @(posedge clk); #1;
        word_ready = 1'b1;
        send(20'h00AA0);
        // Rest of frame 1 with random gaps on both sides.
        rand_ready = 1'b1;
        for (int k = 52; k < 784; k++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            r = int'($urandom_range(0, 8191)) - 2048;
            send(20'(r));
        end
        wait_frame_done(500);
        chk("frame1_words", 32'(words_seen), 32'd196);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rand_ready = 1'b0;
        word_ready = 1'b1;
        chk("start_on_done_ignored", 32'(busy), 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        chk("frame1_done_once", 32'(fd_cnt), 32'd1);
        chk("frame1_rows", 32'(rd_cnt), 32'd28);
        // Reset in the middle of row 10.
        pulse_start();
        chk("busy_frame_a", 32'(busy), 32'd1);
`ifdef RESULT_BUF_SAT_CNT_EN
        chk("sat_cleared_on_start", 32'(sat_count), 32'd0);
`endif
        rd_base = rd_cnt;
        for (int k = 0; k < 285; k++) send(20'((k % 256) * 16));
        chk("rows_before_reset", 32'(rd_cnt - rd_base), 32'd10);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_res_ready", 32'(res_ready), 32'd0);
        chk("mid_rst_word_valid", 32'(word_valid), 32'd0);
        chk("mid_rst_word_data", word_data, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_row_done", 32'(row_done), 32'd0);
        chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        q.delete();
        mlane = 0;
        mpack = '0;
        @(posedge clk); #1;
        // Clean frame after reset; a start pulse mid-row must not disturb it.
        pulse_start();
        rd_base = rd_cnt;
        fd_base = fd_cnt;
        for (int k = 0; k < 28; k++) send(20'(16 * k + 8));
        chk("clean_row0_done", 32'(row_done), 32'd1);
        send(20'h00500);
        send(20'h00510);
        pulse_start();
        chk("start_active_busy", 32'(busy), 32'd1);
        send(20'h00520);
        send(20'h00530);
        chk("start_active_pack", 32'(word_valid), 32'd1);
        chk("start_active_word", word_data, 32'h53525150);
        for (int k = 32; k < 784; k++) send(20'((k % 256) * 16 + 8));
        wait_frame_done(20);
        repeat (2) begin @(posedge clk); #1; end
        chk("clean_rows", 32'(rd_cnt - rd_base), 32'd28);
        chk("clean_done_once", 32'(fd_cnt - fd_base), 32'd1);
        // Results offered while idle are dropped.
        res_valid = 1'b1;
        res_data  = 20'hFFFF0;
        repeat (5) @(negedge clk);
        chk("idle_ready_low", 32'(res_ready), 32'd0);
        chk("idle_no_word", 32'(word_valid), 32'd0);
`ifdef RESULT_BUF_SAT_CNT_EN
        chk("idle_sat_unchanged", 32'(sat_count), 32'd0);
`endif
        @(posedge clk); #1;
        res_valid = 1'b0;
        pulse_start();
        for (int k = 5; k < 9; k++) send(20'(16 * k));
        chk("after_idle_word", word_data, 32'h08070605);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
